// File: rtl/pipelined_iir.sv
// Second-order high-pass IIR in Direct Form II. One sample per clock.
// The recursive state update closes in one cycle; the feed-forward taps are pipelined.
module pipelined_iir #(
  parameter int DATA_W  = 16,
  parameter int COEF_W  = 16,
  parameter int FRAC    = 14,
  parameter int STATE_W = 24,
  parameter int B0      = 13117,
  parameter int B1      = -26234,
  parameter int B2      = 13117,
  parameter int A1      = -25576,
  parameter int A2      = 10508
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y
);

  localparam int ProdW = STATE_W + COEF_W;
  localparam int AccW  = ProdW + 2;

  localparam logic signed [COEF_W-1:0] CoefB0 = COEF_W'(B0);
  localparam logic signed [COEF_W-1:0] CoefB1 = COEF_W'(B1);
  localparam logic signed [COEF_W-1:0] CoefB2 = COEF_W'(B2);
  localparam logic signed [COEF_W-1:0] CoefA1 = COEF_W'(A1);
  localparam logic signed [COEF_W-1:0] CoefA2 = COEF_W'(A2);

  // Clamp limits sign-extended to accumulator width for direct comparison.
  localparam logic signed [AccW-1:0] StateMax = {{(AccW-STATE_W+1){1'b0}}, {(STATE_W-1){1'b1}}};
  localparam logic signed [AccW-1:0] StateMin = {{(AccW-STATE_W+1){1'b1}}, {(STATE_W-1){1'b0}}};
  localparam logic signed [AccW-1:0] DataMax  = {{(AccW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [AccW-1:0] DataMin  = {{(AccW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  function automatic logic signed [ProdW-1:0] mul(input logic signed [COEF_W-1:0]  c,
                                                  input logic signed [STATE_W-1:0] s);
    return ProdW'(c) * ProdW'(s);
  endfunction

  function automatic logic signed [STATE_W-1:0] sat_state(input logic signed [AccW-1:0] v);
    logic signed [AccW-1:0] r;
    if (v > StateMax) begin
      r = StateMax;
    end else if (v < StateMin) begin
      r = StateMin;
    end else begin
      r = v;
    end
    return r[STATE_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [AccW-1:0] v);
    logic signed [AccW-1:0] r;
    if (v > DataMax) begin
      r = DataMax;
    end else if (v < DataMin) begin
      r = DataMin;
    end else begin
      r = v;
    end
    return r[DATA_W-1:0];
  endfunction

  logic signed [DATA_W-1:0]  x_d, x_q;
  logic signed [STATE_W-1:0] w_d, w_q;
  logic signed [STATE_W-1:0] w_d1_d, w_d1_q;
  logic signed [STATE_W-1:0] w_d2_d, w_d2_q;
  logic signed [ProdW-1:0]   p0_d, p0_q;
  logic signed [ProdW-1:0]   p1_d, p1_q;
  logic signed [ProdW-1:0]   p2_d, p2_q;
  logic signed [DATA_W-1:0]  y_d, y_q;
  logic signed [AccW-1:0]    fb_acc;
  logic signed [AccW-1:0]    ff_acc;

  always_comb begin
    x_d = $signed(x);

    // Feedback: must resolve within this cycle since w_q feeds itself.
    fb_acc = (AccW'(x_q) <<< FRAC) - AccW'(mul(CoefA1, w_q)) - AccW'(mul(CoefA2, w_d1_q));
    w_d    = sat_state(fb_acc >>> FRAC);
    w_d1_d = w_q;
    w_d2_d = w_d1_q;

    p0_d = mul(CoefB0, w_q);
    p1_d = mul(CoefB1, w_d1_q);
    p2_d = mul(CoefB2, w_d2_q);

    ff_acc = AccW'(p0_q) + AccW'(p1_q) + AccW'(p2_q);
    y_d    = sat_data(ff_acc >>> FRAC);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q    <= '0;
      w_q    <= '0;
      w_d1_q <= '0;
      w_d2_q <= '0;
      p0_q   <= '0;
      p1_q   <= '0;
      p2_q   <= '0;
      y_q    <= '0;
    end else begin
      x_q    <= x_d;
      w_q    <= w_d;
      w_d1_q <= w_d1_d;
      w_d2_q <= w_d2_d;
      p0_q   <= p0_d;
      p1_q   <= p1_d;
      p2_q   <= p2_d;
      y_q    <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_pipelined_iir.sv
// Bench for pipelined_iir: directed vector table, hand-written corner sequences and
// random stimulus compared against a difference-equation model of the filter.
module tb_pipelined_iir;

  localparam longint MB0 = 13117;
  localparam longint MB1 = -26234;
  localparam longint MB2 = 13117;
  localparam longint MA1 = -25576;
  localparam longint MA2 = 10508;
  localparam real    TwoPi = 6.283185307179586;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] x = 16'd20000;
  logic [15:0] y;

  int checks = 0;
  int failures = 0;

  pipelined_iir dut (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .y     (y)
  );

  always #5 clk = ~clk;

  // Reference: w[n] = x[n] - a1 w[n-1] - a2 w[n-2], y[n] = b0 w[n] + b1 w[n-1] + b2 w[n-2],
  // Q2.14 with floor and clamping, y[n] visible three edges after x[n] is captured.
  longint m_w1, m_w2;
  int     exp_q[$];

  function automatic longint clamp(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    m_w1  = 0;
    m_w2  = 0;
    exp_q = {0, 0, 0};
  endtask

  task automatic model_push(input int xin);
    longint w0, acc;
    w0  = longint'(xin) * 16384 - MA1 * m_w1 - MA2 * m_w2;
    w0  = clamp(w0 >>> 14, -8388608, 8388607);
    acc = MB0 * w0 + MB1 * m_w1 + MB2 * m_w2;
    exp_q.push_back(int'(clamp(acc >>> 14, -32768, 32767)));
    m_w2 = m_w1;
    m_w1 = w0;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic step(input int xin, output int yout);
    int e;
    x = 16'(xin);
    @(posedge clk);
    #1;
    model_push(xin);
    e    = exp_q.pop_front();
    yout = int'($signed(y));
    chk("model", yout, e);
  endtask

  task automatic do_reset(input int cycles);
    x = 16'(20000);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async", int'($signed(y)), 0);
    repeat (cycles) begin
      @(posedge clk);
      #1;
      chk("rst_hold", int'($signed(y)), 0);
    end
    reset = 1'b1;
    model_reset();
  endtask

  function automatic int sine_x(input int n);
    real v;
    v = 10000.0 * $sin(TwoPi * n / 100.0) + 5000.0 * $sin(TwoPi * n / 200.0);
    return $rtoi(v);
  endfunction

  typedef struct {
    bit rst;
    int xin;
    int yexp;
  } vec_t;

  vec_t tbl[19];
  int   rec[150];

  initial begin
    int yv;
    int ok;
    bit hit_hi, hit_lo;

    tbl[0]  = '{1'b1, 10000, 0};
    tbl[1]  = '{1'b0, 0, 0};
    tbl[2]  = '{1'b0, 0, 0};
    tbl[3]  = '{1'b0, 0, 8005};
    tbl[4]  = '{1'b0, 0, -3515};
    tbl[5]  = '{1'b1, 10000, 0};
    tbl[6]  = '{1'b0, 10000, 0};
    tbl[7]  = '{1'b0, 10000, 0};
    tbl[8]  = '{1'b0, 10000, 8005};
    tbl[9]  = '{1'b0, 10000, 4491};
    tbl[10] = '{1'b1, 10000, 0};
    tbl[11] = '{1'b0, -10000, 0};
    tbl[12] = '{1'b0, 10000, 0};
    tbl[13] = '{1'b0, -10000, 8005};
    tbl[14] = '{1'b0, 10000, -11521};
    tbl[15] = '{1'b1, 20000, 0};
    tbl[16] = '{1'b0, 20000, 0};
    tbl[17] = '{1'b0, 20000, 0};
    tbl[18] = '{1'b0, 20000, 16011};

    // Power-on: reset held with a large input present.
    model_reset();
    do_reset(5);

    for (int i = 0; i < 19; i++) begin
      if (tbl[i].rst) do_reset(2);
      step(tbl[i].xin, yv);
      chk($sformatf("table[%0d]", i), yv, tbl[i].yexp);
    end

    // Impulse tail settles.
    do_reset(2);
    step(10000, yv);
    for (int i = 0; i < 205; i++) step(0, yv);
    chk("impulse_decay_abs_lt2", int'(yv > -2 && yv < 2), 1);

    // DC input is rejected.
    do_reset(2);
    for (int i = 0; i < 300; i++) step(10000, yv);
    chk("dc_settle_abs_le2", int'(yv >= -2 && yv <= 2), 1);

    // Nyquist passes at unity gain.
    do_reset(2);
    for (int i = 0; i < 200; i++) step((i % 2 == 0) ? 10000 : -10000, yv);
    for (int i = 0; i < 6; i++) begin
      step((i % 2 == 0) ? 10000 : -10000, yv);
      ok = int'((yv >= 9990 && yv <= 10010) || (yv <= -9990 && yv >= -10010));
      chk("nyquist_gain", ok, 1);
    end

    // Full-scale drive: output must clamp, never wrap.
    do_reset(2);
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step((i % 2 == 0) ? 32767 : -32767, yv);
      if (yv == 32767) hit_hi = 1'b1;
      if (yv == -32768) hit_lo = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 20; i++) begin
        step(32767, yv);
        if (yv == 32767) hit_hi = 1'b1;
      end
      for (int i = 0; i < 20; i++) begin
        step(-32768, yv);
        if (yv == -32768) hit_lo = 1'b1;
      end
    end
    chk("sat_reached_max", int'(hit_hi), 1);
    chk("sat_reached_min", int'(hit_lo), 1);

    // Random stimulus in several amplitude regimes.
    do_reset(2);
    for (int i = 0; i < 600; i++) begin
      int xr;
      case ((i / 100) % 3)
        0:       xr = int'($urandom_range(2000, 0)) - 1000;
        1:       xr = int'($signed(16'($urandom)));
        default: xr = ((i % 7) < 3) ? 32767 : -32768;
      endcase
      step(xr, yv);
    end

    // Async reset mid-stream; the rerun must reproduce a fresh run.
    do_reset(2);
    for (int n = 0; n < 150; n++) begin
      step(sine_x(n), yv);
      rec[n] = yv;
    end
    do_reset(1);
    for (int n = 0; n < 150; n++) begin
      step(sine_x(n), yv);
      chk($sformatf("rerun[%0d]", n), yv, rec[n]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
